// File: rtl/params_pkg.sv
// Shared widths, FSM state type and AXI encodings for the MM2S read path.
package params_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B       = 3'b010;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;

  // Byte enables for the final beat, from the low two bits of the byte length.
  function automatic logic [3:0] keep_for_tail(input logic [1:0] tail);
    case (tail)
      2'd1:    keep_for_tail = 4'h1;
      2'd2:    keep_for_tail = 4'h3;
      2'd3:    keep_for_tail = 4'h7;
      default: keep_for_tail = 4'hF;
    endcase
  endfunction
endpackage

// File: rtl/mm2s_burst_calc.sv
// Beats for the next AR burst: min of MAX_BURST, remaining beats and the
// beats left before the next 4 KB page boundary.
module mm2s_burst_calc #(
  parameter int LEN_WIDTH = 23,
  parameter int MAX_BURST = 16
) (
  input  logic [9:0]           page_word,
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [8:0]           beats
);
  localparam int CW = (LEN_WIDTH > 11) ? LEN_WIDTH : 11;

  logic [10:0]   page_left;
  logic [CW-1:0] page_beats;
  logic [CW-1:0] rem_beats;
  logic [CW-1:0] max_beats;
  logic [CW-1:0] min_rm;

  always_comb begin
    // page_word is addr[11:2], so this is (4096 - addr[11:0]) / 4, range 1..1024
    page_left  = 11'h400 - {1'b0, page_word};
    page_beats = CW'(page_left);
    rem_beats  = CW'(remaining);
    max_beats  = CW'(MAX_BURST);
    min_rm     = (rem_beats < max_beats) ? rem_beats : max_beats;
    beats      = 9'((page_beats < min_rm) ? page_beats : min_rm);
  end
endmodule

// File: rtl/mm2s_read_master.sv
// AXI4 memory-mapped to AXI4-Stream read master: splits a byte-length command
// into 4 KB-safe INCR bursts, one outstanding, through a one-entry output stage.
module mm2s_read_master
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 23
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] m_axi_mm2s_araddr,
  output logic [7:0]            m_axi_mm2s_arlen,
  output logic [2:0]            m_axi_mm2s_arsize,
  output logic [1:0]            m_axi_mm2s_arburst,
  output logic [2:0]            m_axi_mm2s_arprot,
  output logic [3:0]            m_axi_mm2s_arcache,
  output logic                  m_axi_mm2s_arvalid,
  input  logic                  m_axi_mm2s_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_mm2s_rdata,
  input  logic [1:0]            m_axi_mm2s_rresp,
  input  logic                  m_axi_mm2s_rlast,
  input  logic                  m_axi_mm2s_rvalid,
  output logic                  m_axi_mm2s_rready,
  output logic [DATA_WIDTH-1:0] m_axis_mm2s_tdata,
  output logic [3:0]            m_axis_mm2s_tkeep,
  output logic                  m_axis_mm2s_tlast,
  output logic                  m_axis_mm2s_tvalid,
  input  logic                  m_axis_mm2s_tready,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; a source holds its payload stable while valid=1 and ready=0.

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [8:0]            burst_left_q;
  logic [8:0]            cur_burst_q;
  logic [1:0]            tail_q;
  logic                  err_sticky_q;
  logic [8:0]            calc_beats;
  logic [LEN_WIDTH-1:0]  total_beats;
  logic                  out_free;
  logic                  r_fire;
  logic                  last_of_burst;

  mm2s_burst_calc #(
    .LEN_WIDTH (LEN_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .page_word (addr_q[11:2]),
    .remaining (remaining_q),
    .beats     (calc_beats)
  );

  assign total_beats   = LEN_WIDTH'(cmd_len[LEN_WIDTH-1:2]) + LEN_WIDTH'(|cmd_len[1:0]);
  assign out_free      = !m_axis_mm2s_tvalid || m_axis_mm2s_tready;
  assign r_fire        = (state_q == DATA) && out_free && m_axi_mm2s_rvalid;
  assign last_of_burst = (burst_left_q == 9'd1);

  assign m_axi_mm2s_rready  = (state_q == DATA) && out_free;
  assign m_axi_mm2s_araddr  = addr_q;
  assign m_axi_mm2s_arlen   = 8'(calc_beats - 9'd1);
  assign m_axi_mm2s_arsize  = SIZE_4B;
  assign m_axi_mm2s_arburst = BURST_INCR;
  assign m_axi_mm2s_arprot  = PROT_DEFAULT;
  assign m_axi_mm2s_arcache = CACHE_DEFAULT;
  assign busy               = (state_q != IDLE);

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    cmd_ready          = 1'b0;
    m_axi_mm2s_arvalid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_len == '0) ? DONE : ADDR;
      end
      ADDR: begin
        m_axi_mm2s_arvalid = 1'b1;
        if (m_axi_mm2s_arready) state_d = DATA;
      end
      DATA: begin
        if (r_fire && last_of_burst)
          state_d = (remaining_q == LEN_WIDTH'(1)) ? DONE : ADDR;
      end
      DONE: begin
        if (!m_axis_mm2s_tvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      addr_q             <= '0;
      remaining_q        <= '0;
      burst_left_q       <= '0;
      cur_burst_q        <= '0;
      tail_q             <= '0;
      err_sticky_q       <= 1'b0;
      m_axis_mm2s_tdata  <= '0;
      m_axis_mm2s_tkeep  <= '0;
      m_axis_mm2s_tlast  <= 1'b0;
      m_axis_mm2s_tvalid <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
    end else begin
      done <= 1'b0;
      // A beat loaded below in the same cycle overrides this drain.
      if (m_axis_mm2s_tvalid && m_axis_mm2s_tready) m_axis_mm2s_tvalid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            err_sticky_q <= 1'b0;
            err          <= 1'b0;
            addr_q       <= cmd_addr;
            remaining_q  <= total_beats;
            tail_q       <= cmd_len[1:0];
          end
        end
        ADDR: begin
          if (m_axi_mm2s_arready) begin
            cur_burst_q  <= calc_beats;
            burst_left_q <= calc_beats;
          end
        end
        DATA: begin
          if (r_fire) begin
            m_axis_mm2s_tdata  <= m_axi_mm2s_rdata;
            m_axis_mm2s_tvalid <= 1'b1;
            m_axis_mm2s_tlast  <= (remaining_q == LEN_WIDTH'(1));
            m_axis_mm2s_tkeep  <= (remaining_q == LEN_WIDTH'(1)) ? keep_for_tail(tail_q) : 4'hF;
            remaining_q        <= remaining_q - LEN_WIDTH'(1);
            burst_left_q       <= burst_left_q - 9'd1;
            if ((m_axi_mm2s_rresp != RESP_OKAY) || (m_axi_mm2s_rlast != last_of_burst))
              err_sticky_q <= 1'b1;
            if (last_of_burst)
              addr_q <= addr_q + ADDR_WIDTH'({cur_burst_q, 2'b00});
          end
        end
        DONE: begin
          if (!m_axis_mm2s_tvalid) begin
            done <= 1'b1;
            err  <= err_sticky_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mm2s_read_master.sv
// Directed bench for mm2s_read_master: AXI read slave model, stream sink with
// scoreboard, and hand-computed AR/beat expectations per command.
module tb_mm2s_read_master;
  logic        axi_aclk;
  logic        axi_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [22:0] cmd_len;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [2:0]  arprot;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        done;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stall_from = 0;
  int stall_to = 0;
  int r_beat = 0;
  int err_beat = -1;

  logic [36:0] exp_q[$];     // {tlast, tkeep, tdata}
  logic [39:0] exp_ar_q[$];  // {araddr, arlen}

  mm2s_read_master dut (
    .axi_aclk           (axi_aclk),
    .axi_reset          (axi_reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_addr           (cmd_addr),
    .cmd_len            (cmd_len),
    .m_axi_mm2s_araddr  (araddr),
    .m_axi_mm2s_arlen   (arlen),
    .m_axi_mm2s_arsize  (arsize),
    .m_axi_mm2s_arburst (arburst),
    .m_axi_mm2s_arprot  (arprot),
    .m_axi_mm2s_arcache (arcache),
    .m_axi_mm2s_arvalid (arvalid),
    .m_axi_mm2s_arready (arready),
    .m_axi_mm2s_rdata   (rdata),
    .m_axi_mm2s_rresp   (rresp),
    .m_axi_mm2s_rlast   (rlast),
    .m_axi_mm2s_rvalid  (rvalid),
    .m_axi_mm2s_rready  (rready),
    .m_axis_mm2s_tdata  (tdata),
    .m_axis_mm2s_tkeep  (tkeep),
    .m_axis_mm2s_tlast  (tlast),
    .m_axis_mm2s_tvalid (tvalid),
    .m_axis_mm2s_tready (tready),
    .done               (done),
    .err                (err),
    .busy               (busy)
  );

  // clock / reset
  initial begin
    axi_aclk = 1'b0;
    forever #5 axi_aclk = ~axi_aclk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // AXI read slave: one cycle AR wait, then the burst from mem_word
  initial begin : axi_slave
    logic [31:0] a;
    logic [7:0]  l;
    int n;
    logic hs;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    forever begin
      @(negedge axi_aclk);
      if (!axi_reset && arvalid) begin
        a = araddr; l = arlen; n = int'(arlen) + 1;
        if (exp_ar_q.size() == 0) check("ar_unexpected", {a, l}, 40'h0);
        else check("ar_addr_len", {a, l}, exp_ar_q.pop_front());
        check("ar_const", {arsize, arburst, arprot, arcache}, {3'b010, 2'b01, 3'b000, 4'b0011});
        @(negedge axi_aclk);
        check("ar_stable", {arvalid, araddr, arlen}, {1'b1, a, l});
        arready = 1'b1;
        @(negedge axi_aclk);
        arready = 1'b0;
        for (int i = 0; i < n && !axi_reset; i++) begin
          rvalid = 1'b1;
          rdata  = mem_word(a + 32'(4 * i));
          rresp  = (r_beat == err_beat) ? 2'b10 : 2'b00;
          rlast  = (i == n - 1);
          hs = 1'b0;
          while (!hs && !axi_reset) begin
            #1 hs = rready;
            @(negedge axi_aclk);
          end
          r_beat++;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end
    end
  end

  // stream sink + scoreboard
  initial begin : stream_sink
    logic [36:0] got;
    tready = 1'b0;
    forever begin
      @(negedge axi_aclk);
      cyc++;
      tready = !(cyc >= stall_from && cyc < stall_to);
      #1;
      if (!axi_reset && tvalid && !tready) check("rready_stall", rready, 1'b0);
      if (!axi_reset && tvalid && tready) begin
        got = {tlast, tkeep, tdata};
        if (exp_q.size() == 0) check("beat_unexpected", got, 37'h0);
        else check("beat", got, exp_q.pop_front());
      end
    end
  end

  task automatic expect_beats(input logic [31:0] a, input int nbeats, input logic [3:0] last_keep);
    for (int b = 0; b < nbeats; b++)
      exp_q.push_back({(b == nbeats - 1), (b == nbeats - 1) ? last_keep : 4'hF,
                       mem_word(a + 32'(4 * b))});
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [22:0] len);
    int k;
    r_beat = 0;
    @(negedge axi_aclk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = len;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge axi_aclk);
      k++;
    end
    check("cmd_ready", cmd_ready, 1'b1);
    @(negedge axi_aclk);
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("err_cleared", err, 1'b0);
  endtask

  task automatic wait_done(input logic exp_err);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge axi_aclk);
      k++;
    end
    check("done", done, 1'b1);
    check("done_err", err, exp_err);
    check("tvalid_drained", tvalid, 1'b0);
    check("beats_left", exp_q.size(), 0);
    check("ars_left", exp_ar_q.size(), 0);
    @(negedge axi_aclk);
    check("done_pulse", done, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin : main
    int k;
    axi_reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(negedge axi_aclk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_outs", {arvalid, rready, tvalid, tlast, done, err, busy}, 7'h0);
    check("rst_tkeep_tdata", {tkeep, tdata}, 36'h0);
    axi_reset = 1'b0;
    @(negedge axi_aclk);
    check("post_rst_ready", cmd_ready, 1'b1);

    // single full burst
    exp_ar_q.push_back({32'h0000_1000, 8'd15});
    expect_beats(32'h0000_1000, 16, 4'hF);
    send_cmd(32'h0000_1000, 23'd64);
    wait_done(1'b0);

    // 4 KB crossing
    exp_ar_q.push_back({32'h0000_0FF0, 8'd3});
    exp_ar_q.push_back({32'h0000_1000, 8'd3});
    expect_beats(32'h0000_0FF0, 8, 4'hF);
    send_cmd(32'h0000_0FF0, 23'd32);
    wait_done(1'b0);

    // partial final beat, len 10 -> keep 3
    exp_ar_q.push_back({32'h0000_2000, 8'd2});
    expect_beats(32'h0000_2000, 3, 4'h3);
    send_cmd(32'h0000_2000, 23'd10);
    wait_done(1'b0);

    // len 80 with a 5-cycle tready stall mid-burst
    exp_ar_q.push_back({32'h0000_3000, 8'd15});
    exp_ar_q.push_back({32'h0000_3040, 8'd3});
    expect_beats(32'h0000_3000, 20, 4'hF);
    stall_from = cyc + 12; stall_to = cyc + 17;
    send_cmd(32'h0000_3000, 23'd80);
    wait_done(1'b0);

    // SLVERR on beat 2 of 4, then a clean command
    exp_ar_q.push_back({32'h0000_4000, 8'd3});
    expect_beats(32'h0000_4000, 4, 4'hF);
    err_beat = 1;
    send_cmd(32'h0000_4000, 23'd16);
    wait_done(1'b1);
    err_beat = -1;
    exp_ar_q.push_back({32'h0000_5000, 8'd1});
    expect_beats(32'h0000_5000, 2, 4'hF);
    send_cmd(32'h0000_5000, 23'd8);
    wait_done(1'b0);

    // zero length: no AR
    send_cmd(32'h0000_5000, 23'd0);
    wait_done(1'b0);

    // len 13 just below a page edge: 2+2 beats, keep 1
    exp_ar_q.push_back({32'h0000_7FF8, 8'd1});
    exp_ar_q.push_back({32'h0000_8000, 8'd1});
    expect_beats(32'h0000_7FF8, 4, 4'h1);
    send_cmd(32'h0000_7FF8, 23'd13);
    wait_done(1'b0);

    // len 7 -> 2 beats, keep 7
    exp_ar_q.push_back({32'h0000_9000, 8'd1});
    expect_beats(32'h0000_9000, 2, 4'h7);
    send_cmd(32'h0000_9000, 23'd7);
    wait_done(1'b0);

    // reset during DATA
    exp_ar_q.push_back({32'h0000_6000, 8'd15});
    expect_beats(32'h0000_6000, 16, 4'hF);
    send_cmd(32'h0000_6000, 23'd64);
    k = 0;
    while (!tvalid && k < 200) begin
      @(negedge axi_aclk);
      k++;
    end
    check("reached_data", tvalid, 1'b1);
    axi_reset = 1'b1;
    #2;
    check("rst_mid_outs", {arvalid, rready, tvalid, busy}, 4'h0);
    repeat (2) @(negedge axi_aclk);
    exp_q.delete();
    exp_ar_q.delete();
    axi_reset = 1'b0;
    @(posedge axi_aclk);
    #1;
    check("rst_release_ready", cmd_ready, 1'b1);
    check("rst_release_arvalid", arvalid, 1'b0);
    repeat (3) @(negedge axi_aclk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
